alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Brief    : Issues one operation at a time to an external combinational ALU,
//             waits out the ALU-reported extra cycles and commits the result
//             and PSW flags. Supports abort and direct flag loads.
//  Revision : 1.0  initial release
// ============================================================================

package alu_sequencer_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'd0,
        ALU_ADDC = 3'd1,
        ALU_SUB  = 3'd2,
        ALU_AND  = 3'd3,
        ALU_OR   = 3'd4,
        ALU_XOR  = 3'd5,
        ALU_ROL  = 3'd6,
        ALU_SHL  = 3'd7
    } alu_operation_e;

    typedef struct packed {
        logic s;   // sign
        logic z;   // zero
        logic ac;  // auxiliary (nibble) carry
        logic ov;  // signed overflow
        logic cy;  // carry
    } flags_t;

endpackage

module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  alu_operation_e op,
    input  logic [15:0]    op_a,
    input  logic [15:0]    op_b,
    input  logic           op_wide,
    input  logic           abort,
    input  logic           flags_wr,
    input  flags_t         flags_wr_data,
    output alu_operation_e alu_op,
    output logic [15:0]    alu_ta,
    output logic [15:0]    alu_tb,
    output logic           alu_wide,
    output flags_t         alu_flags_in,
    input  logic [15:0]    alu_result,
    input  logic [9:0]     alu_cycles,
    input  flags_t         alu_flags,
    output logic           busy,
    output logic           done,
    output logic [15:0]    result,
    output flags_t         flags
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e         state_q,      state_d;
    alu_operation_e op_q,         op_d;
    logic [15:0]    ta_q,         ta_d;
    logic [15:0]    tb_q,         tb_d;
    logic           wide_q,       wide_d;
    logic [9:0]     cnt_q,        cnt_d;
    logic [15:0]    pend_res_q,   pend_res_d;
    flags_t         pend_flg_q,   pend_flg_d;
    logic [15:0]    result_q,     result_d;
    flags_t         flags_q,      flags_d;

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            op_q       <= ALU_ADD;
            ta_q       <= 16'h0000;
            tb_q       <= 16'h0000;
            wide_q     <= 1'b0;
            cnt_q      <= 10'd0;
            pend_res_q <= 16'h0000;
            pend_flg_q <= '0;
            result_q   <= 16'h0000;
            flags_q    <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            ta_q       <= ta_d;
            tb_q       <= tb_d;
            wide_q     <= wide_d;
            cnt_q      <= cnt_d;
            pend_res_q <= pend_res_d;
            pend_flg_q <= pend_flg_d;
            result_q   <= result_d;
            flags_q    <= flags_d;
        end
    end

    // Next-state logic: accept/latch, capture ALU output, count down, commit.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        ta_d       = ta_q;
        tb_d       = tb_q;
        wide_d     = wide_q;
        cnt_d      = cnt_q;
        pend_res_d = pend_res_q;
        pend_flg_d = pend_flg_q;
        result_d   = result_q;
        flags_d    = flags_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // Direct flag load lands before EXEC, so a same-cycle start
                // presents the new flags to the ALU.
                if (flags_wr) begin
                    flags_d = flags_wr_data;
                end
                if (start) begin
                    op_d    = op;
                    ta_d    = op_a;
                    tb_d    = op_b;
                    wide_d  = op_wide;
                    state_d = S_EXEC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    pend_res_d = alu_result;
                    pend_flg_d = alu_flags;
                    cnt_d      = alu_cycles;
                    if (alu_cycles == 10'd0) begin
                        // Zero-latency op: commit straight from the ALU since
                        // the pending registers are only being written now.
                        state_d  = S_DONE;
                        result_d = alu_result;
                        flags_d  = alu_flags;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 10'd1;
                    if (cnt_q == 10'd1) begin
                        state_d  = S_DONE;
                        result_d = pend_res_q;
                        flags_d  = pend_flg_q;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy         = (state_q == S_EXEC) || (state_q == S_WAIT);
    assign done         = (state_q == S_DONE);
    assign alu_op       = op_q;
    assign alu_ta       = ta_q;
    assign alu_tb       = tb_q;
    assign alu_wide     = wide_q;
    assign alu_flags_in = flags_q;
    assign result       = result_q;
    assign flags        = flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Brief    : Self-checking bench for alu_sequencer with a behavioural ALU and
//             a transaction-level model of commit timing, result and flags.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    typedef struct packed {
        flags_t      f;
        logic [15:0] r;
    } alu_out_t;

    logic           clk = 1'b0;
    logic           reset_n;
    logic           start;
    alu_operation_e op;
    logic [15:0]    op_a;
    logic [15:0]    op_b;
    logic           op_wide;
    logic           abort;
    logic           flags_wr;
    flags_t         flags_wr_data;
    alu_operation_e alu_op;
    logic [15:0]    alu_ta;
    logic [15:0]    alu_tb;
    logic           alu_wide;
    flags_t         alu_flags_in;
    logic [15:0]    alu_result;
    logic [9:0]     alu_cycles;
    flags_t         alu_flags;
    logic           busy;
    logic           done;
    logic [15:0]    result;
    flags_t         flags;

    int             n_tests = 0;
    int             n_fail  = 0;
    logic [15:0]    m_result;
    flags_t         m_flags;

    alu_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .op            (op),
        .op_a          (op_a),
        .op_b          (op_b),
        .op_wide       (op_wide),
        .abort         (abort),
        .flags_wr      (flags_wr),
        .flags_wr_data (flags_wr_data),
        .alu_op        (alu_op),
        .alu_ta        (alu_ta),
        .alu_tb        (alu_tb),
        .alu_wide      (alu_wide),
        .alu_flags_in  (alu_flags_in),
        .alu_result    (alu_result),
        .alu_cycles    (alu_cycles),
        .alu_flags     (alu_flags),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .flags         (flags)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: byte results are zero-extended to 16 bits.
    function automatic alu_out_t alu_fn(alu_operation_e o, logic [15:0] a,
                                        logic [15:0] b, logic w, flags_t fi);
        alu_out_t    res;
        int unsigned width, mask, am, bm, r, t, cin, n;
        logic        ma, mb, mr;
        width = w ? 16 : 8;
        mask  = w ? 32'h0000FFFF : 32'h000000FF;
        am    = {16'h0, a} & mask;
        bm    = {16'h0, b} & mask;
        res.f = fi;
        r     = 0;
        cin   = (o == ALU_ADDC && fi.cy) ? 1 : 0;
        case (o)
            ALU_ADD, ALU_ADDC: begin
                t        = am + bm + cin;
                r        = t & mask;
                res.f.cy = (t > mask);
                res.f.ac = (((am & 15) + (bm & 15) + cin) > 15);
            end
            ALU_SUB: begin
                r        = (am - bm) & mask;
                res.f.cy = (am < bm);
                res.f.ac = ((am & 15) < (bm & 15));
            end
            ALU_AND, ALU_OR, ALU_XOR: begin
                r        = (o == ALU_AND) ? (am & bm) : (o == ALU_OR) ? (am | bm) : (am ^ bm);
                res.f.cy = 1'b0;
                res.f.ac = 1'b0;
                res.f.ov = 1'b0;
            end
            ALU_ROL: begin
                n = bm % width;
                r = ((am << n) | (am >> (width - n))) & mask;
            end
            default: begin
                r = (bm >= width) ? 0 : ((am << bm) & mask);
            end
        endcase
        ma = ((am >> (width - 1)) & 1) != 0;
        mb = ((bm >> (width - 1)) & 1) != 0;
        mr = ((r  >> (width - 1)) & 1) != 0;
        if (o == ALU_ADD || o == ALU_ADDC) res.f.ov = (ma == mb) && (mr != ma);
        if (o == ALU_SUB)                  res.f.ov = (ma != mb) && (mr != ma);
        res.r   = r[15:0];
        res.f.z = (r == 0);
        res.f.s = mr;
        return res;
    endfunction

    always_comb begin
        alu_out_t ao;
        ao         = alu_fn(alu_op, alu_ta, alu_tb, alu_wide, alu_flags_in);
        alu_result = ao.r;
        alu_flags  = ao.f;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE or DONE and follow it to commit or abort.
    // abort_at selects the busy cycle (1 = EXEC) in which abort is raised.
    task automatic run_op(input alu_operation_e o, input logic [15:0] a,
                          input logic [15:0] b, input logic w, input int c,
                          input logic fw, input flags_t fwd,
                          input int abort_at, input logic noise);
        alu_out_t exp;
        if (fw) m_flags = fwd;
        exp           = alu_fn(o, a, b, w, m_flags);
        start         = 1'b1;
        op            = o;
        op_a          = a;
        op_b          = b;
        op_wide       = w;
        flags_wr      = fw;
        flags_wr_data = fwd;
        alu_cycles    = 10'(c);
        tick();
        start    = 1'b0;
        flags_wr = 1'b0;
        for (int k = 1; k <= c + 1; k++) begin
            chk("busy_hi", {31'b0, busy}, 32'd1);
            chk("done_lo", {31'b0, done}, 32'd0);
            chk("res_hold", {16'b0, result}, {16'b0, m_result});
            chk("flg_hold", {27'b0, flags}, {27'b0, m_flags});
            if (k == abort_at) abort = 1'b1;
            if (noise) begin
                start         = 1'($urandom_range(0, 1));
                op            = alu_operation_e'($urandom_range(0, 7));
                op_a          = 16'($urandom);
                op_b          = 16'($urandom);
                flags_wr      = 1'($urandom_range(0, 1));
                flags_wr_data = flags_t'($urandom_range(0, 31));
            end
            tick();
            abort    = 1'b0;
            start    = 1'b0;
            flags_wr = 1'b0;
            if (k == abort_at) begin
                chk("abort_busy", {31'b0, busy}, 32'd0);
                chk("abort_done", {31'b0, done}, 32'd0);
                chk("abort_res", {16'b0, result}, {16'b0, m_result});
                chk("abort_flg", {27'b0, flags}, {27'b0, m_flags});
                return;
            end
        end
        m_result = exp.r;
        m_flags  = exp.f;
        chk("done_hi", {31'b0, done}, 32'd1);
        chk("busy_lo", {31'b0, busy}, 32'd0);
        chk("result", {16'b0, result}, {16'b0, m_result});
        chk("flags", {27'b0, flags}, {27'b0, m_flags});
    endtask

    initial begin
        flags_t fl;
        reset_n       = 1'b0;
        start         = 1'b0;
        op            = ALU_ADD;
        op_a          = 16'h0;
        op_b          = 16'h0;
        op_wide       = 1'b0;
        abort         = 1'b0;
        flags_wr      = 1'b0;
        flags_wr_data = '0;
        alu_cycles    = 10'd0;
        m_result      = 16'h0;
        m_flags       = '0;
        tick();
        tick();
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_res", {16'b0, result}, 32'd0);
        chk("rst_flg", {27'b0, flags}, 32'd0);
        chk("rst_op", {29'b0, alu_op}, {29'b0, ALU_ADD});
        reset_n = 1'b1;
        tick();

        // ADD, zero extra cycles
        run_op(ALU_ADD, 16'h1234, 16'h0001, 1'b1, 0, 1'b0, '0, -1, 1'b0);
        chk("add_res", {16'b0, result}, 32'h1235);
        chk("add_z", {31'b0, flags.z}, 32'd0);
        chk("add_cy", {31'b0, flags.cy}, 32'd0);

        // ROL issued in the DONE cycle, with start noise during WAIT
        run_op(ALU_ROL, 16'h8001, 16'h0005, 1'b1, 5, 1'b0, '0, -1, 1'b1);
        chk("rol_res", {16'b0, result}, 32'h0030);

        // Further back-to-back op
        run_op(ALU_SUB, 16'h0005, 16'h0007, 1'b1, 3, 1'b0, '0, -1, 1'b1);
        tick();
        chk("idle_busy", {31'b0, busy}, 32'd0);
        chk("idle_done", {31'b0, done}, 32'd0);

        // Abort in the second WAIT cycle
        run_op(ALU_ROL, 16'h1111, 16'h0003, 1'b1, 8, 1'b0, '0, 3, 1'b0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("abort_no_done", {31'b0, done}, 32'd0);
        end
        chk("abort_keep_res", {16'b0, result}, {16'b0, m_result});

        // Direct flag load then byte ADDC
        fl            = '0;
        fl.cy         = 1'b1;
        flags_wr      = 1'b1;
        flags_wr_data = fl;
        tick();
        flags_wr = 1'b0;
        m_flags  = fl;
        chk("fload", {27'b0, flags}, {27'b0, fl});
        run_op(ALU_ADDC, 16'h00FF, 16'h0000, 1'b0, 0, 1'b0, '0, -1, 1'b0);
        chk("addc_res", {16'b0, result}, 32'h0000);
        chk("addc_cy", {31'b0, flags.cy}, 32'd1);
        chk("addc_z", {31'b0, flags.z}, 32'd1);
        chk("addc_ac", {31'b0, flags.ac}, 32'd1);
        tick();

        // Randomized operations against the model
        for (int it = 0; it < 60; it++) begin
            int c;
            int ab;
            c  = int'($urandom_range(0, 7));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, c + 1)) : -1;
            run_op(alu_operation_e'($urandom_range(0, 7)), 16'($urandom), 16'($urandom),
                   1'($urandom_range(0, 1)), c, ($urandom_range(0, 3) == 0),
                   flags_t'($urandom_range(0, 31)), ab, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 1) == 1) begin
                flags_wr      = 1'($urandom_range(0, 1));
                flags_wr_data = flags_t'($urandom_range(0, 31));
                tick();
                if (flags_wr) m_flags = flags_wr_data;
                flags_wr = 1'b0;
                chk("gap_busy", {31'b0, busy}, 32'd0);
                chk("gap_flg", {27'b0, flags}, {27'b0, m_flags});
            end
        end

        // Reset during WAIT, with other controls asserted and ignored
        start      = 1'b1;
        op         = ALU_XOR;
        op_a       = 16'hA5A5;
        op_b       = 16'h5A5A;
        op_wide    = 1'b1;
        alu_cycles = 10'd6;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset_n       = 1'b0;
        start         = 1'b1;
        abort         = 1'b1;
        flags_wr      = 1'b1;
        flags_wr_data = '1;
        tick();
        start    = 1'b0;
        abort    = 1'b0;
        flags_wr = 1'b0;
        reset_n  = 1'b1;
        m_result = 16'h0;
        m_flags  = '0;
        chk("wrst_busy", {31'b0, busy}, 32'd0);
        chk("wrst_done", {31'b0, done}, 32'd0);
        chk("wrst_res", {16'b0, result}, 32'd0);
        chk("wrst_flg", {27'b0, flags}, 32'd0);
        chk("wrst_ta", {16'b0, alu_ta}, 32'd0);
        chk("wrst_tb", {16'b0, alu_tb}, 32'd0);
        chk("wrst_wide", {31'b0, alu_wide}, 32'd0);
        chk("wrst_op", {29'b0, alu_op}, {29'b0, ALU_ADD});
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("wrst_no_done", {31'b0, done}, 32'd0);
            chk("wrst_idle", {31'b0, busy}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
